dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single data-memory port between the RISC-V core (req 0) and a debug/loader master (req 1).
// - Sits between core dmem signals and the dmem instance inside top.
// - Round-robin arbitration, per-cycle grant, 1-cycle read-response routing.
// - Optional debug lock with bounded hold so the core cannot starve.
// PARAMETERS
// - AW        32  address width
// - DW        32  data width
// - MAX_LOCK  16  max consecutive cycles req 1 may hold the port under lock (>=2)
// PORTS
// - clk              in   1   clock; all state updates on rising edge
// - reset            in   1   synchronous, active-high reset
// - c_req            in   1   core requests a dmem access this cycle
// - c_we             in   1   core access is a write
// - c_addr           in   AW  core byte address
// - c_wdata          in   DW  core write data
// - c_gnt            out  1   core access performed this cycle
// - c_rvalid         out  1   core read data valid (cycle after granted read)
// - c_rdata          out  DW  core read data
// - d_req/d_we       in   1   debug request / write
// - d_addr           in   AW  debug address
// - d_wdata          in   DW  debug write data
// - d_lock           in   1   debug requests exclusive ownership
// - d_gnt/d_rvalid   out  1   debug grant / read valid
// - d_rdata          out  DW  debug read data
// - dmem_addr        out  AW  memory address
// - dmem_write_data  out  DW  memory write data
// - dmem_write       out  1   memory write enable
// - dmem_read        out  1   memory read enable
// - dmem_read_data   in   DW  memory read data, valid 1 cycle after dmem_read
// BEHAVIOUR
// - Reset: state=ARB; prio=core; lock_cnt=0; c_gnt/d_gnt/c_rvalid/d_rvalid/dmem_write/dmem_read=0.
// - At most one grant per cycle. Grant is combinational from req + registered state; no wait cycle.
// - dmem_* mux the granted requester's address, data and write enable.
// - dmem_read = gnt & ~we. Without a grant, dmem_write=0 and dmem_read=0.
// - ARB:
//   - one requester asking -> it is granted.
//   - both asking -> grant the requester named by prio.
//   - after a contested grant, prio flips to the loser.
// - ARB -> LOCK: d_gnt & d_lock. lock_cnt is loaded with 1.
// - LOCK:
//   - core is never granted.
//   - d_gnt = d_req. lock_cnt increments every cycle, whether or not d_req is high.
//   - LOCK -> ARB when d_lock=0, or when lock_cnt==MAX_LOCK-1.
//   - On a forced exit (lock_cnt==MAX_LOCK-1), prio=core for the next contest.
// - Read response:
//   - registered tag {valid, owner} is captured on each granted read.
//   - next cycle: the owner's rvalid=1 and its rdata=dmem_read_data.
//   - the other requester's rvalid=0; its rdata is don't-care (drive 0).
// - Granted writes take effect at the clock edge of the grant cycle; no response pulse.
// - Back-to-back granted reads give one rvalid per cycle, in grant order.
// - Reset mid-operation:
//   - any pending response tag is dropped (no rvalid after reset).
//   - lock is cleared.
// - Address/data pass through unmodified; the arbiter does no alignment checking.
// CONFIGURATION
// - DMEM_ARB_STATS_EN defined:
//   - adds outputs stat_c_stall[31:0] and stat_d_grants[31:0].
//   - stat_c_stall counts cycles with c_req & ~c_gnt.
//   - stat_d_grants counts d_gnt cycles.
//   - both counters are saturating and cleared by reset.
// - DMEM_ARB_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - Package dmem_arb_pkg:
//   - arb_state_e {ARB, LOCK}
//   - owner_e {OWN_CORE, OWN_DBG}
//   - rsp_tag_t struct {valid, owner}
// - Sub-module dmem_arb_stats: holds the two saturating counters; instantiated only under DMEM_ARB_STATS_EN.
// - All arbitration, lock FSM and response routing live in dmem_port_arbiter.
// TESTING
// 1. Reset: reset=1 for 2 cycles with c_req=d_req=1 -> all gnt/rvalid/dmem_write/dmem_read are 0.
// 2. Core only: c_req=1, c_we=1, c_addr=100, c_wdata=25 -> same cycle c_gnt=1, dmem_write=1,
//    dmem_addr=100, dmem_write_data=25.
// 3. Contention: c_req=d_req=1 for 4 cycles, reads, after reset -> grants C,D,C,D.
//    Each c_rvalid/d_rvalid appears 1 cycle after its grant with the mem word for its address.
// 4. Lock: d_req=d_lock=1 held with MAX_LOCK=16 and c_req=1 ->
//    - d_gnt high for 16 cycles (1 ARB + 15 LOCK).
//    - then c_gnt=1 on the next cycle.
// 5. Early unlock: d_lock drops after 3 lock cycles, c_req=1 -> c_gnt on the following cycle; state=ARB.
// 6. Reset mid-read: granted d read at cycle N, reset=1 at cycle N+1 -> d_rvalid stays 0.
//    With DMEM_ARB_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, response
// owner encoding, the registered read-response tag and the statistics width.
package dmem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rsp_tag_t;

    localparam int STAT_W = 32;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating activity counters for the dmem port arbiter: cycles in which the
// core was kept waiting, and cycles in which the debug master owned the port.
// Only instantiated when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              c_stall,
    input  logic              d_grant,
    output logic [STAT_W-1:0] stat_c_stall,
    output logic [STAT_W-1:0] stat_d_grants
);

    // Count stalled core cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_c_stall <= '0;
        end else if (c_stall && (stat_c_stall != '1)) begin
            stat_c_stall <= stat_c_stall + STAT_W'(1);
        end
    end

    // Count debug-owned cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_d_grants <= '0;
        end else if (d_grant && (stat_d_grants != '1)) begin
            stat_d_grants <= stat_d_grants + STAT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the core (requester 0) and a
// debug/loader master (requester 1). Round-robin grant decided in the same
// cycle as the request, one-cycle read-response routing back to whichever
// requester issued the read, and an optional debug lock that is forcibly
// released after MAX_LOCK consecutive debug-owned cycles so the core cannot
// starve.
// Optional feature: define DMEM_ARB_STATS_EN to add the stat_c_stall and
// stat_d_grants saturating counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_write_data,
    output logic          dmem_write,
    output logic          dmem_read,
    input  logic [DW-1:0] dmem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_c_stall,
    output logic [STAT_W-1:0] stat_d_grants
`endif
);

    localparam int            CW        = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

    arb_state_e    state;
    owner_e        prio;
    logic [CW-1:0] lock_cnt;
    rsp_tag_t      rsp_tag;
    logic          sel_we;
    logic          any_gnt;

    // Grant decision from the live requests and the registered FSM state;
    // nothing is granted while reset is asserted
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state == LOCK) begin
                d_gnt = d_req;
            end else if (c_req && d_req) begin
                c_gnt = (prio == OWN_CORE);
                d_gnt = (prio == OWN_DBG);
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end
    end

    // Steer the granted requester onto the memory port; the core is the idle default
    always_comb begin
        any_gnt = c_gnt | d_gnt;
        if (d_gnt) begin
            dmem_addr       = d_addr;
            dmem_write_data = d_wdata;
            sel_we          = d_we;
        end else begin
            dmem_addr       = c_addr;
            dmem_write_data = c_wdata;
            sel_we          = c_we;
        end
        dmem_write = any_gnt & sel_we;
        dmem_read  = any_gnt & ~sel_we;
    end

    // Round-robin priority and debug-lock FSM with bounded hold time
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            prio     <= OWN_CORE;
            lock_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (c_req && d_req) begin
                        prio <= c_gnt ? OWN_DBG : OWN_CORE;
                    end
                    if (d_gnt && d_lock) begin
                        state    <= LOCK;
                        lock_cnt <= CW'(1);
                    end
                end
                LOCK: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state    <= ARB;
                        prio     <= OWN_CORE;
                        lock_cnt <= '0;
                    end else if (!d_lock) begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Remember who issued this cycle's granted read so next cycle's data goes back to them
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_tag <= '{valid: 1'b0, owner: OWN_CORE};
        end else begin
            rsp_tag.valid <= dmem_read;
            rsp_tag.owner <= d_gnt ? OWN_DBG : OWN_CORE;
        end
    end

    // Route the memory read data to the tagged owner; the other side sees zero
    always_comb begin
        c_rvalid = ~reset & rsp_tag.valid & (rsp_tag.owner == OWN_CORE);
        d_rvalid = ~reset & rsp_tag.valid & (rsp_tag.owner == OWN_DBG);
        c_rdata  = c_rvalid ? dmem_read_data : '0;
        d_rdata  = d_rvalid ? dmem_read_data : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk           (clk),
        .reset         (reset),
        .c_stall       (c_req & ~c_gnt),
        .d_grant       (d_gnt),
        .stat_c_stall  (stat_c_stall),
        .stat_d_grants (stat_d_grants)
    );
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a small behavioural memory
// behind the port. Inputs change on the falling edge; checks are taken 1 ns
// later, mid-cycle, so combinational grants and registered responses are stable.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] dmem_addr, dmem_write_data, dmem_read_data;
    logic        dmem_write, dmem_read;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_c_stall, stat_d_grants;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [256];
    logic        written [256];
    logic        mem_clear;

    dmem_port_arbiter #(.AW(32), .DW(32), .MAX_LOCK(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .c_req           (c_req),
        .c_we            (c_we),
        .c_addr          (c_addr),
        .c_wdata         (c_wdata),
        .c_gnt           (c_gnt),
        .c_rvalid        (c_rvalid),
        .c_rdata         (c_rdata),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_lock          (d_lock),
        .d_gnt           (d_gnt),
        .d_rvalid        (d_rvalid),
        .d_rdata         (d_rdata),
        .dmem_addr       (dmem_addr),
        .dmem_write_data (dmem_write_data),
        .dmem_write      (dmem_write),
        .dmem_read       (dmem_read),
        .dmem_read_data  (dmem_read_data)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_c_stall    (stat_c_stall),
        .stat_d_grants   (stat_d_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten word at address a reads as 32'hD000_0000 | a
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else if (dmem_write) begin
            mem[dmem_addr[7:0]]     <= dmem_write_data;
            written[dmem_addr[7:0]] <= 1'b1;
        end
        if (dmem_read) begin
            dmem_read_data <= written[dmem_addr[7:0]] ? mem[dmem_addr[7:0]]
                                                      : (32'hD000_0000 | {24'd0, dmem_addr[7:0]});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rst,
                                 input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                                 input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                                 input logic dl);
        @(negedge clk);
        reset   = rst;
        c_req   = cr;
        c_we    = cwe;
        c_addr  = ca;
        c_wdata = cwd;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_lock  = dl;
        #1;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        mem_clear = 1'b1;
        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;

        // Reset held two cycles with both requesters asking
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0);
        checkBit("rst_c_gnt", c_gnt, 1'b0);
        checkBit("rst_d_gnt", d_gnt, 1'b0);
        checkBit("rst_dmem_read", dmem_read, 1'b0);
        checkBit("rst_dmem_write", dmem_write, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0);
        mem_clear = 1'b0;
        checkBit("rst_c_rvalid", c_rvalid, 1'b0);
        checkBit("rst_d_rvalid", d_rvalid, 1'b0);
        checkBit("rst2_c_gnt", c_gnt, 1'b0);
        checkBit("rst2_d_gnt", d_gnt, 1'b0);

        // Core-only write of 25 to address 100
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd100, 32'd25, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("wr_c_gnt", c_gnt, 1'b1);
        checkBit("wr_d_gnt", d_gnt, 1'b0);
        checkBit("wr_dmem_write", dmem_write, 1'b1);
        checkBit("wr_dmem_read", dmem_read, 1'b0);
        checkOutput("wr_dmem_addr", dmem_addr, 32'd100);
        checkOutput("wr_dmem_wdata", dmem_write_data, 32'd25);

        // One reset cycle so contention starts from core priority
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("wr_no_rvalid", c_rvalid, 1'b0);

        // Contended reads: grants C,D,C,D with responses one cycle later
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd10, 32'd0, 1'b1, 1'b0, 32'd40, 32'd0, 1'b0);
        checkBit("ct0_c_gnt", c_gnt, 1'b1);
        checkBit("ct0_d_gnt", d_gnt, 1'b0);
        checkBit("ct0_dmem_read", dmem_read, 1'b1);
        checkOutput("ct0_dmem_addr", dmem_addr, 32'd10);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd11, 32'd0, 1'b1, 1'b0, 32'd41, 32'd0, 1'b0);
        checkBit("ct1_d_gnt", d_gnt, 1'b1);
        checkBit("ct1_c_gnt", c_gnt, 1'b0);
        checkOutput("ct1_dmem_addr", dmem_addr, 32'd41);
        checkBit("ct1_c_rvalid", c_rvalid, 1'b1);
        checkOutput("ct1_c_rdata", c_rdata, 32'hD000_000A);
        checkBit("ct1_d_rvalid", d_rvalid, 1'b0);
        checkOutput("ct1_d_rdata", d_rdata, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 1'b0, 32'd42, 32'd0, 1'b0);
        checkBit("ct2_c_gnt", c_gnt, 1'b1);
        checkOutput("ct2_dmem_addr", dmem_addr, 32'd12);
        checkBit("ct2_d_rvalid", d_rvalid, 1'b1);
        checkOutput("ct2_d_rdata", d_rdata, 32'hD000_0029);
        checkBit("ct2_c_rvalid", c_rvalid, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd13, 32'd0, 1'b1, 1'b0, 32'd43, 32'd0, 1'b0);
        checkBit("ct3_d_gnt", d_gnt, 1'b1);
        checkOutput("ct3_dmem_addr", dmem_addr, 32'd43);
        checkBit("ct3_c_rvalid", c_rvalid, 1'b1);
        checkOutput("ct3_c_rdata", c_rdata, 32'hD000_000C);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("rd100_c_gnt", c_gnt, 1'b1);
        checkBit("ct3_d_rvalid", d_rvalid, 1'b1);
        checkOutput("ct3_d_rdata", d_rdata, 32'hD000_002B);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("rd100_c_rvalid", c_rvalid, 1'b1);
        checkOutput("rd100_c_rdata", c_rdata, 32'd25);

        // Lock: core wins first contest, then debug holds 1 ARB + 15 LOCK cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1);
        checkBit("lk_pre_c_gnt", c_gnt, 1'b1);
        checkBit("lk_pre_d_gnt", d_gnt, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1);
            checkBit("lk_hold_d_gnt", d_gnt, 1'b1);
            checkBit("lk_hold_c_gnt", c_gnt, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1);
        checkBit("lk_exit_c_gnt", c_gnt, 1'b1);
        checkBit("lk_exit_d_gnt", d_gnt, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Early unlock after 3 lock cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1);
        checkBit("ul_arb_d_gnt", d_gnt, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1);
            checkBit("ul_lock_d_gnt", d_gnt, 1'b1);
            checkBit("ul_lock_c_gnt", c_gnt, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0);
        checkBit("ul_drop_d_gnt", d_gnt, 1'b1);
        checkBit("ul_drop_c_gnt", c_gnt, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0);
        checkBit("ul_after_c_gnt", c_gnt, 1'b1);
        checkBit("ul_after_d_gnt", d_gnt, 1'b0);

        // Debug write of 77 to address 60, then core reads it back
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd60, 32'd77, 1'b0);
        checkBit("dw_d_gnt", d_gnt, 1'b1);
        checkBit("dw_dmem_write", dmem_write, 1'b1);
        checkBit("dw_dmem_read", dmem_read, 1'b0);
        checkOutput("dw_dmem_addr", dmem_addr, 32'd60);
        checkOutput("dw_dmem_wdata", dmem_write_data, 32'd77);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd60, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("rd60_c_gnt", c_gnt, 1'b1);
        checkBit("dw_no_d_rvalid", d_rvalid, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("rd60_c_rvalid", c_rvalid, 1'b1);
        checkOutput("rd60_c_rdata", c_rdata, 32'd77);

        // Reset in the cycle after a granted debug read drops the response
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd50, 32'd0, 1'b0);
        checkBit("mr_d_gnt", d_gnt, 1'b1);
        checkBit("mr_dmem_read", dmem_read, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("mr_rst_d_rvalid", d_rvalid, 1'b0);
        checkOutput("mr_rst_d_rdata", d_rdata, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("mr_post_d_rvalid", d_rvalid, 1'b0);
        checkBit("mr_post_c_rvalid", c_rvalid, 1'b0);
`ifdef DMEM_ARB_STATS_EN
        checkOutput("mr_stat_c_stall", stat_c_stall, 32'd0);
        checkOutput("mr_stat_d_grants", stat_d_grants, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
